cam_cfg_seq: RTL
================

CAM_CFG_SEQ -- requirements
Module: cam_cfg_seq

Interface
REQ-001 SHALL have parameter REG_AW, default 8, sensor register address width.
REQ-002 SHALL have parameter REG_DW, default 8, sensor register data width.
REQ-003 SHALL have parameter IDX_W, default 8, entry-index width per profile.
REQ-004 SHALL have parameter PROF_W, default 1, profile-select width (2^PROF_W profiles).
REQ-005 SHALL have parameter DELAY_UNIT, default 24000, clock cycles per delay unit (1 ms at 24 MHz).
REQ-006 SHALL have parameter MAX_RETRY, default 3, NACK retries per entry before error.
REQ-007 i_clk  in  1  sole clock, all logic on rising edge.
REQ-008 i_rstn  in  1  asynchronous active-low reset.
REQ-009 i_start  in  1  one-cycle pulse that begins a configuration run.
REQ-010 i_profile  in  PROF_W  profile to run, sampled on accepted i_start.
REQ-011 o_rom_addr  out  PROF_W+IDX_W  table address {profile, index}.
REQ-012 i_rom_data  in  REG_AW+REG_DW  table word {reg addr, reg data}, valid one cycle after o_rom_addr changes.
REQ-013 o_wr_valid  out  1  write request to the SCCB master.
REQ-014 o_wr_addr  out  REG_AW  register address of the request.
REQ-015 o_wr_data  out  REG_DW  register data of the request.
REQ-016 i_wr_ready  in  1  master accepts the request when high with o_wr_valid.
REQ-017 i_wr_done  in  1  one-cycle pulse, accepted transaction finished.
REQ-018 i_wr_nack  in  1  qualified by i_wr_done; 1 = transaction NACKed.
REQ-019 o_busy  out  1  high from accepted start until DONE or ERROR.
REQ-020 o_done  out  1  one-cycle pulse on successful completion.
REQ-021 o_err  out  1  level, high in ERROR until next accepted start.
REQ-022 o_index  out  IDX_W  index of entry currently processed (error location).

Function
REQ-023 Entry decode: reg addr all-ones and data all-ones = END; reg addr all-ones, other data = DELAY of data*DELAY_UNIT cycles; anything else = WRITE.
REQ-024 DELAY with data 0 SHALL proceed to next entry with no wait.
REQ-025 States: IDLE, FETCH, WAIT, DECODE, WRITE, RESP, DELAY, DONE, ERROR.
REQ-026 IDLE: i_start accepted -> latch i_profile, index=0, clear o_err, retry count=0, go FETCH.
REQ-027 i_start in any state other than IDLE, DONE, ERROR SHALL be ignored.
REQ-028 FETCH drives o_rom_addr, WAIT absorbs ROM latency, DECODE registers i_rom_data and branches per REQ-023.
REQ-029 WRITE: o_wr_valid=1 with o_wr_addr/o_wr_data stable until i_wr_ready; then RESP with o_wr_valid=0 next cycle.
REQ-030 RESP: i_wr_done&!i_wr_nack -> advance; i_wr_done&i_wr_nack -> retry WRITE if retry<MAX_RETRY (retry+1), else ERROR.
REQ-031 Retry count SHALL clear on each index advance.
REQ-032 DELAY: counter loaded data*DELAY_UNIT-1, counts to 0, then advance; counter width sized for (2^REG_DW-2)*DELAY_UNIT.
REQ-033 Advance: index+1 and FETCH; if index is 2^IDX_W-1 (no END found) SHALL go DONE instead of wrapping.
REQ-034 END -> DONE; DONE asserts o_done one cycle, o_busy=0, returns to IDLE next cycle.
REQ-035 ERROR holds o_err=1, o_busy=0 until i_start, then behaves as REQ-026.
REQ-036 i_wr_done outside RESP SHALL be ignored.
REQ-037 Entry-to-entry latency excluding write/delay: FETCH+WAIT+DECODE = 3 cycles.

Reset
REQ-038 While i_rstn=0: state IDLE, o_rom_addr=0, o_wr_valid=0, o_wr_addr=0, o_wr_data=0, o_busy=0, o_done=0, o_err=0, o_index=0, counters 0.
REQ-039 Reset mid-run SHALL abort immediately; no further request issued after deassertion until new i_start.

Verification
REQ-040 Table p0 {12_80, FF_02, 12_04, FF_FF}, DELAY_UNIT=4, start p0, ready/done immediate -> writes 12/80 then 12/04, 8-cycle gap of no valid, o_done once, o_busy low after.
REQ-041 i_wr_ready held low 10 cycles -> o_wr_valid and addr/data stable all 10 cycles, single transfer.
REQ-042 NACK on entry 2 four times, MAX_RETRY=3 -> four requests for entry 2, then o_err=1, o_index=2, no o_done.
REQ-043 Profile 1 table with no END, IDX_W=3 -> 8 writes at o_rom_addr 8..15, then o_done, no access to address 0.
REQ-044 i_start during DELAY and during RESP -> ignored, run completes unchanged; i_rstn low during DELAY -> all outputs 0, idle until next start.
REQ-045 Entry FF_00 -> zero-cycle delay, next FETCH follows DECODE directly.

Source files
------------

// File: rtl/cam_cfg_seq.sv
// Camera sensor configuration sequencer: walks a per-profile register table
// and issues SCCB writes, timed delays and NACK retries until an END entry.
module cam_cfg_seq #(
  parameter int unsigned REG_AW     = 8,
  parameter int unsigned REG_DW     = 8,
  parameter int unsigned IDX_W      = 8,
  parameter int unsigned PROF_W     = 1,
  parameter int unsigned DELAY_UNIT = 24000,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_start,
  input  logic [PROF_W-1:0]       i_profile,
  output logic [PROF_W+IDX_W-1:0] o_rom_addr,
  input  logic [REG_AW+REG_DW-1:0] i_rom_data,
  output logic                    o_wr_valid,
  output logic [REG_AW-1:0]       o_wr_addr,
  output logic [REG_DW-1:0]       o_wr_data,
  input  logic                    i_wr_ready,
  input  logic                    i_wr_done,
  input  logic                    i_wr_nack,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err,
  output logic [IDX_W-1:0]        o_index
);

  localparam longint unsigned DLY_MAX = ((64'd1 << REG_DW) - 64'd2) * 64'(DELAY_UNIT);
  localparam int unsigned CNT_W  = (DLY_MAX > 1) ? $clog2(DLY_MAX + 1) : 1;
  localparam int unsigned RTRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_WRITE, S_RESP, S_DELAY, S_DONE, S_ERROR
  } state_t;

  state_t              state_q, state_nxt;
  logic [PROF_W-1:0]   prof_q, prof_nxt;
  logic [IDX_W-1:0]    idx_q, idx_nxt;
  logic [REG_AW-1:0]   addr_q, addr_nxt;
  logic [REG_DW-1:0]   data_q, data_nxt;
  logic [RTRY_W-1:0]   retry_q, retry_nxt;
  logic [CNT_W-1:0]    cnt_q, cnt_nxt;

  logic [REG_AW-1:0]   rom_a;
  logic [REG_DW-1:0]   rom_d;
  logic [CNT_W-1:0]    dly_load;
  logic                adv;

  assign rom_a    = i_rom_data[REG_AW+REG_DW-1:REG_DW];
  assign rom_d    = i_rom_data[REG_DW-1:0];
  assign dly_load = CNT_W'(rom_d) * CNT_W'(DELAY_UNIT) - CNT_W'(1);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      prof_q  <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      retry_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      prof_q  <= prof_nxt;
      idx_q   <= idx_nxt;
      addr_q  <= addr_nxt;
      data_q  <= data_nxt;
      retry_q <= retry_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    prof_nxt  = prof_q;
    idx_nxt   = idx_q;
    addr_nxt  = addr_q;
    data_nxt  = data_q;
    retry_nxt = retry_q;
    cnt_nxt   = cnt_q;
    adv       = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_start) begin
          prof_nxt  = i_profile;
          idx_nxt   = '0;
          retry_nxt = '0;
          cnt_nxt   = '0;
          state_nxt = S_FETCH;
        end else if (state_q == S_DONE) begin
          state_nxt = S_IDLE;
        end
      end
      S_FETCH: state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_DECODE;
      S_DECODE: begin
        addr_nxt = rom_a;
        data_nxt = rom_d;
        if (rom_a == '1) begin
          if (rom_d == '1) begin
            state_nxt = S_DONE;
          end else if (rom_d == '0) begin
            adv = 1'b1;
          end else begin
            cnt_nxt   = dly_load;
            state_nxt = S_DELAY;
          end
        end else begin
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (i_wr_ready) state_nxt = S_RESP;
      end
      S_RESP: begin
        if (i_wr_done) begin
          if (!i_wr_nack) begin
            adv = 1'b1;
          end else if (retry_q < RTRY_W'(MAX_RETRY)) begin
            retry_nxt = retry_q + RTRY_W'(1);
            state_nxt = S_WRITE;
          end else begin
            state_nxt = S_ERROR;
          end
        end
      end
      S_DELAY: begin
        if (cnt_q == '0) adv = 1'b1;
        else             cnt_nxt = cnt_q - CNT_W'(1);
      end
      default: state_nxt = S_IDLE;
    endcase

    // One shared advance path so the last-index stop applies to writes, delays and zero delays alike
    if (adv) begin
      retry_nxt = '0;
      if (idx_q == '1) begin
        state_nxt = S_DONE;
      end else begin
        idx_nxt   = idx_q + IDX_W'(1);
        state_nxt = S_FETCH;
      end
    end
  end

  assign o_rom_addr = {prof_q, idx_q};
  assign o_index    = idx_q;
  assign o_wr_addr  = addr_q;
  assign o_wr_data  = data_q;
  assign o_wr_valid = (state_q == S_WRITE);
  assign o_done     = (state_q == S_DONE);
  assign o_err      = (state_q == S_ERROR);
  assign o_busy     = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);

endmodule
